convg_frame_seq: RTL and testbench

- Frame sequencer for the streaming 3x3 line-buffer convolution datapath.
- Gates upstream pixel beats into the datapath and pulses the datapath's buffer clear at frame start.
- Generates per-beat row-boundary flags and the datapath stall.
- Injects zero flush beats after the last input, and presents a valid/ready output stream aligned to the datapath's registered output.

---
 rtl/convg_frame_seq.sv | 195 +++++++++++++++++++
 tb/tb_convg_frame_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/convg_frame_seq.sv
// Frame sequencer for the 3x3 line-buffer conv datapath; optional stall counters under CONVG_FRAME_SEQ_STAT_EN.
// Latency: first output beat valid BPR+1 advances after frame start; BPR+1 zero flush beats drain the pipe.
// Backpressure: an unconsumed out beat (out_valid & !out_ready) freezes the datapath and deasserts in_ready.
module convg_frame_seq #(
    parameter int IM_LEN       = 520,
    parameter int IM_HEIGHT    = 520,
    parameter int PIX_PER_BEAT = 4,
    parameter int CW           = 16
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*PIX_PER_BEAT-1:0] in_data,
    output logic [8*PIX_PER_BEAT-1:0] conv_data,
    output logic                      conv_clrbuffer,
    output logic [1:0]                conv_rowend,
    output logic                      conv_stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof,
`ifdef CONVG_FRAME_SEQ_STAT_EN
    output logic [31:0]               stall_in_cnt,
    output logic [31:0]               stall_out_cnt,
`endif
    output logic                      busy,
    output logic                      frame_done
);

    localparam int BPR = IM_LEN / PIX_PER_BEAT;
    localparam int TOT = BPR * IM_HEIGHT;
    localparam int LAT = BPR + 1;

    localparam logic [31:0]   TOT_C    = 32'(TOT);
    localparam logic [31:0]   LAT_C    = 32'(LAT);
    localparam logic [31:0]   END_C    = 32'(TOT + LAT);
    localparam logic [CW-1:0] COL_LAST = CW'(BPR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   adv_cnt;
    logic [31:0]   adv_nxt;
    logic [31:0]   out_idx;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] out_col;

    logic in_phase;
    logic flush_phase;
    logic out_block;
    logic adv;
    logic emit;

    assign in_phase    = (state == S_FILL) || (state == S_RUN);
    assign flush_phase = (state == S_FLUSH);
    assign out_block   = out_valid & ~out_ready;

    assign in_ready   = in_phase & ~out_block;
    assign adv        = (in_phase & in_valid & ~out_block) | (flush_phase & ~out_block);
    assign conv_stall = ~adv;
    assign conv_data  = in_phase ? in_data : '0;

    // bit1 low on the last beat of a row, bit0 low on the first
    assign conv_rowend = {col != COL_LAST, col != '0};

    // the advance that fills the window presents output beat out_idx
    assign adv_nxt = adv_cnt + 32'd1;
    assign emit    = (adv_nxt >= LAT_C) && (out_idx < TOT_C);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state          <= S_IDLE;
            adv_cnt        <= '0;
            out_idx        <= '0;
            col            <= '0;
            row            <= '0;
            out_col        <= '0;
            out_valid      <= 1'b0;
            out_sof        <= 1'b0;
            out_eol        <= 1'b0;
            out_eof        <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            conv_clrbuffer <= 1'b0;
        end else begin
            conv_clrbuffer <= 1'b0;
            frame_done     <= 1'b0;

            if (adv) begin
                adv_cnt <= adv_nxt;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                out_valid <= emit;
                if (emit) begin
                    out_sof <= (out_idx == 32'd0);
                    out_eol <= (out_col == COL_LAST);
                    out_eof <= (out_idx == TOT_C - 32'd1);
                    out_idx <= out_idx + 32'd1;
                    out_col <= (out_col == COL_LAST) ? '0 : out_col + 1'b1;
                end else begin
                    out_sof <= 1'b0;
                    out_eol <= 1'b0;
                    out_eof <= 1'b0;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_CLEAR;
                        conv_clrbuffer <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    adv_cnt   <= '0;
                    out_idx   <= '0;
                    col       <= '0;
                    row       <= '0;
                    out_col   <= '0;
                    out_valid <= 1'b0;
                    out_sof   <= 1'b0;
                    out_eol   <= 1'b0;
                    out_eof   <= 1'b0;
                    state     <= S_FILL;
                end
                S_FILL: begin
                    // a frame shorter than the window goes straight to flush
                    if (adv) begin
                        if (adv_nxt == TOT_C)
                            state <= S_FLUSH;
                        else if (adv_nxt == LAT_C)
                            state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (adv && adv_nxt == TOT_C)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (adv && adv_nxt == END_C) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONVG_FRAME_SEQ_STAT_EN
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stall_in_cnt  <= '0;
            stall_out_cnt <= '0;
        end else if (state == S_CLEAR) begin
            stall_in_cnt  <= '0;
            stall_out_cnt <= '0;
        end else begin
            if (in_phase && !in_valid && stall_in_cnt != '1)
                stall_in_cnt <= stall_in_cnt + 32'd1;
            if (out_block && stall_out_cnt != '1)
                stall_out_cnt <= stall_out_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_convg_frame_seq.sv
// Randomized bench for convg_frame_seq with a frame-level reference model.
module tb_convg_frame_seq;

    localparam int IM_LEN    = 8;
    localparam int IM_HEIGHT = 3;
    localparam int PPB       = 4;
    localparam int CW        = 16;
    localparam int BPR       = IM_LEN / PPB;
    localparam int TOT       = BPR * IM_HEIGHT;
    localparam int LAT       = BPR + 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_IN    = 2;
    localparam int PH_FLUSH = 3;
    localparam int PH_DONE  = 4;

    logic            clk;
    logic            res;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [8*PPB-1:0] in_data;
    logic [8*PPB-1:0] conv_data;
    logic            conv_clrbuffer;
    logic [1:0]      conv_rowend;
    logic            conv_stall;
    logic            out_valid;
    logic            out_ready;
    logic            out_sof;
    logic            out_eol;
    logic            out_eof;
    logic            busy;
    logic            frame_done;
`ifdef CONVG_FRAME_SEQ_STAT_EN
    logic [31:0]     stall_in_cnt;
    logic [31:0]     stall_out_cnt;
`endif

    convg_frame_seq #(
        .IM_LEN(IM_LEN), .IM_HEIGHT(IM_HEIGHT), .PIX_PER_BEAT(PPB), .CW(CW)
    ) dut (
        .clk(clk), .res(res), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .conv_data(conv_data), .conv_clrbuffer(conv_clrbuffer),
        .conv_rowend(conv_rowend), .conv_stall(conv_stall),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
`ifdef CONVG_FRAME_SEQ_STAT_EN
        .stall_in_cnt(stall_in_cnt), .stall_out_cnt(stall_out_cnt),
`endif
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // frame-level model: phase, advance count, presented output index
    int  m_phase, m_adv, m_oidx, m_sin, m_sout;
    bit  m_ov;
    bit  e_blk, e_inr, e_adv;
    logic [1:0] e_re;

    // per-frame observations of the DUT, relative to the start cycle
    int rel, clr_rel, ov_first, ov_cnt, hs_cnt, done_rel;
    int done_seen = 0;
    logic [1:0] rowend_q[$];

    always @(negedge clk) begin
        if (res) begin
            m_phase = PH_IDLE; m_adv = 0; m_ov = 0; m_oidx = 0; m_sin = 0; m_sout = 0;
            chk("rst_busy",     32'(busy), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_stall",    32'(conv_stall), 32'd1);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_clr",      32'(conv_clrbuffer), 32'd0);
            chk("rst_done",     32'(frame_done), 32'd0);
`ifdef CONVG_FRAME_SEQ_STAT_EN
            chk("rst_stall_in",  stall_in_cnt, 32'd0);
            chk("rst_stall_out", stall_out_cnt, 32'd0);
`endif
        end else begin
            rel++;
            e_blk = m_ov && !out_ready;
            e_inr = (m_phase == PH_IN) && !e_blk;
            e_adv = (m_phase == PH_IN) ? (in_valid && e_inr) : ((m_phase == PH_FLUSH) && !e_blk);
            e_re  = {(m_adv % BPR) != BPR - 1, (m_adv % BPR) != 0};

            chk("busy",       32'(busy), 32'(m_phase != PH_IDLE));
            chk("clrbuffer",  32'(conv_clrbuffer), 32'(m_phase == PH_CLEAR));
            chk("frame_done", 32'(frame_done), 32'(m_phase == PH_DONE));
            chk("in_ready",   32'(in_ready), 32'(e_inr));
            chk("conv_stall", 32'(conv_stall), 32'(!e_adv));
            chk("rowend",     32'(conv_rowend), 32'(e_re));
            chk("out_valid",  32'(out_valid), 32'(m_ov));
            if (m_phase == PH_IN)
                chk("conv_data", conv_data, in_data);
            else if (m_phase == PH_FLUSH)
                chk("flush_data", conv_data, 32'd0);
            if (m_ov) begin
                chk("out_sof", 32'(out_sof), 32'(m_oidx == 0));
                chk("out_eol", 32'(out_eol), 32'(m_oidx % BPR == BPR - 1));
                chk("out_eof", 32'(out_eof), 32'(m_oidx == TOT - 1));
            end
`ifdef CONVG_FRAME_SEQ_STAT_EN
            chk("stall_in_cnt",  stall_in_cnt, 32'(m_sin));
            chk("stall_out_cnt", stall_out_cnt, 32'(m_sout));
`endif
            if (conv_clrbuffer) clr_rel = rel;
            if (out_valid) begin
                ov_cnt++;
                if (ov_first < 0) ov_first = rel;
            end
            if (!conv_stall) rowend_q.push_back(conv_rowend);
            if (out_valid && out_ready) hs_cnt++;
            if (frame_done) begin
                done_rel = rel;
                done_seen++;
                chk("frame_handshakes", hs_cnt, TOT);
            end

            if (m_phase == PH_CLEAR) begin
                m_sin = 0; m_sout = 0;
            end else begin
                if (m_phase == PH_IN && !in_valid) m_sin++;
                if (e_blk) m_sout++;
            end
            if (e_adv) begin
                m_adv++;
                m_ov = (m_adv >= LAT) && (m_adv - LAT < TOT);
                if (m_ov) m_oidx = m_adv - LAT;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            case (m_phase)
                PH_IDLE: if (start) begin
                    m_phase = PH_CLEAR;
                    rel = 0; clr_rel = -1; ov_first = -1; ov_cnt = 0; hs_cnt = 0; done_rel = -1;
                    rowend_q.delete();
                end
                PH_CLEAR: begin m_phase = PH_IN; m_adv = 0; m_ov = 0; end
                PH_IN:    if (e_adv && m_adv == TOT) m_phase = PH_FLUSH;
                PH_FLUSH: if (e_adv && m_adv == TOT + LAT) m_phase = PH_DONE;
                default:  m_phase = PH_IDLE;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            start     = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            cyc();
        end
    endtask

    // mode 0 steady, 1 in_valid toggling, 2 two input gaps + four output stalls, 3 random
    task automatic run_frame(input int mode);
        int d0;
        int i;
        d0 = done_seen;
        i  = 0;
        while (done_seen == d0 && i < 300) begin
            in_data = $urandom;
            if (i == 0)
                start = 1'b1;
            else if (mode == 3)
                start = (busy && !frame_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            else
                start = 1'b0;
            case (mode)
                0: begin in_valid = 1'b1; out_ready = 1'b1; end
                1: begin in_valid = (i % 2 == 0); out_ready = 1'b1; end
                2: begin in_valid = !(i == 2 || i == 3); out_ready = !(i >= 8 && i <= 11); end
                default: begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            endcase
            cyc();
            i++;
        end
        chk("frame_completed", done_seen - d0, 1);
        start = 1'b0;
    endtask

    logic [1:0] re_exp [0:8];

    initial begin
        re_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        res = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        idle_cycles(3);

        run_frame(0);
        chk("a_clr_cycle",   clr_rel, 1);
        chk("a_first_ov",    ov_first, 5);
        chk("a_ov_cycles",   ov_cnt, 6);
        chk("a_done_cycle",  done_rel, 11);
        chk("a_rowend_len",  rowend_q.size(), 9);
        for (int k = 0; k < 9; k++)
            if (k < rowend_q.size()) chk("a_rowend_seq", 32'(rowend_q[k]), 32'(re_exp[k]));

        idle_cycles(2);
        run_frame(1);
        chk("b_ov_cycles", ov_cnt, 6);
        chk("b_hs",        hs_cnt, 6);

        idle_cycles(2);
        run_frame(2);
        chk("c_ov_cycles",  ov_cnt, 10);
        chk("c_done_cycle", done_rel, 17);
`ifdef CONVG_FRAME_SEQ_STAT_EN
        chk("c_stall_in",  stall_in_cnt, 32'd2);
        chk("c_stall_out", stall_out_cnt, 32'd4);
`endif

        idle_cycles(2);
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        res = 1'b1;
        @(negedge clk);
        chk("r_busy",      32'(busy), 32'd0);
        chk("r_out_valid", 32'(out_valid), 32'd0);
        chk("r_stall",     32'(conv_stall), 32'd1);
        @(posedge clk);
        #1 res = 1'b0;
        idle_cycles(2);
        run_frame(0);
        chk("r2_ov_cycles",  ov_cnt, 6);
        chk("r2_done_cycle", done_rel, 11);

        for (int f = 0; f < 8; f++) begin
            idle_cycles($urandom_range(1, 4));
            run_frame(3);
        end
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
